// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//
// Purpose: 32-bit sequential restoring divider, one quotient bit per clock.
//   A start accepted in IDLE captures the operands, runs 32 restoring steps
//   on operand magnitudes (MSB first), applies sign / divide-by-zero
//   correction in FIX and presents the registered results with a one-cycle
//   done pulse.  Accept-to-done latency is always 33 edges.
//
// Configuration:
//   SEQ_DIVIDER_SIGNED_EN  defined   -> signed_op=1 selects signed division
//                                       (quotient truncates toward zero,
//                                       remainder takes the dividend's sign)
//                          undefined -> signed_op is ignored, all divides
//                                       are unsigned
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  synchronous active-low reset
//   start      in   1  request a divide (sampled only in IDLE)
//   signed_op  in   1  1 = signed (DIV), 0 = unsigned (DIVU)
//   dividend   in  32  numerator, captured on accept
//   divisor    in  32  denominator, captured on accept
//   quotient   out 32  registered quotient
//   remainder  out 32  registered remainder
//   busy       out  1  high in RUN, FIX and DONE
//   done       out  1  one-cycle completion pulse
//   div_zero   out  1  divisor was zero; valid with done, held with results
//
// Handshake: start is a request that is taken only while busy=0; there is
//   no queueing, so a start raised while busy=1 is simply dropped.  Results
//   are valid in the done cycle and stay stable until the next operation
//   writes new ones at its FIX->DONE edge.
// ---------------------------------------------------------------------------
module seq_divider (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        signed_op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nx;

   logic [4:0]  cnt;       // remaining iterations after the current one
   logic [31:0] prem;      // partial remainder
   logic [31:0] pquo;      // dividend magnitude shifting out, quotient in
   logic [31:0] dmag;      // divisor magnitude
   logic [31:0] dvd_raw;   // dividend as captured, for the divide-by-zero result
   logic        neg_q;     // quotient must be negated in FIX
   logic        neg_r;     // remainder must be negated in FIX
   logic        dz;        // captured divisor was zero

   // Effective signed mode: tied low when signed support is compiled out.
   logic        sop;
`ifdef SEQ_DIVIDER_SIGNED_EN
   assign sop = signed_op;
`else
   logic        unused_signed_op;
   assign sop              = 1'b0;
   assign unused_signed_op = signed_op;
`endif

   // Operand magnitudes.  Negating 0x80000000 yields 0x80000000, which read
   // as unsigned is exactly 2^31, so the most negative value needs no
   // special case.
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   assign a_mag = (sop && dividend[31]) ? (~dividend + 32'd1) : dividend;
   assign b_mag = (sop && divisor[31])  ? (~divisor  + 32'd1) : divisor;

   // One restoring step.  The partial remainder is always below dmag
   // (<= 2^31), so the shifted value fits 33 bits and bit 32 of the trial
   // difference is a reliable "went negative" flag.
   logic [32:0] shifted;
   logic [32:0] trial;
   assign shifted = {prem, pquo[31]};
   assign trial   = shifted - {1'b0, dmag};

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ------------------------------------------------------------------
   // FSM next state and status outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      busy     = 1'b1;
      done     = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nx = RUN;
         end
         RUN: begin
            if (cnt == 5'd0) state_nx = FIX;
         end
         FIX: begin
            state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath and result registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt       <= 5'd0;
         prem      <= 32'd0;
         pquo      <= 32'd0;
         dmag      <= 32'd0;
         dvd_raw   <= 32'd0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         dz        <= 1'b0;
         quotient  <= 32'd0;
         remainder <= 32'd0;
         div_zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cnt     <= 5'd31;
                  prem    <= 32'd0;
                  pquo    <= a_mag;
                  dmag    <= b_mag;
                  dvd_raw <= dividend;
                  neg_q   <= sop && (dividend[31] ^ divisor[31]);
                  neg_r   <= sop && dividend[31];
                  dz      <= (divisor == 32'd0);
               end
            end
            RUN: begin
               if (!trial[32]) begin
                  prem <= trial[31:0];
                  pquo <= {pquo[30:0], 1'b1};
               end else begin
                  prem <= shifted[31:0];
                  pquo <= {pquo[30:0], 1'b0};
               end
               if (cnt != 5'd0) cnt <= cnt - 5'd1;
            end
            FIX: begin
               // With sop=0 both negate flags are zero and this is a
               // plain pass-through of the unsigned result.
               if (dz) begin
                  quotient  <= 32'hFFFF_FFFF;
                  remainder <= dvd_raw;
                  div_zero  <= 1'b1;
               end else begin
                  quotient  <= neg_q ? (~pquo + 32'd1) : pquo;
                  remainder <= neg_r ? (~prem + 32'd1) : prem;
                  div_zero  <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//
// Directed self-checking bench for seq_divider.  Each scenario task drives
// its own stimulus and compares the DUT against hand-computed values.
// Inputs change on the falling edge (or right after it); outputs are sampled
// on the falling edge.  Expected signed results depend on whether
// SEQ_DIVIDER_SIGNED_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_seq_divider;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        signed_op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        busy;
   logic        done;
   logic        div_zero;

   int total = 0;
   int bad   = 0;

   // Results the DUT should currently be holding (bench model state).
   logic [31:0] exp_q = 32'd0;
   logic [31:0] exp_r = 32'd0;
   logic        exp_z = 1'b0;

   seq_divider dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .signed_op (signed_op),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver ----------------
   // Raise start with the given operands now, take the next rising edge as
   // E0, drop start, then watch falling edges until done.  lat is the number
   // of edges after E0 at which done is first seen (-1 on timeout).  busy_ok
   // clears if busy is ever low before done; hold_ok clears if the outputs
   // move away from exp_q/exp_r/exp_z before done.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat, output bit busy_ok, output bit hold_ok);
      dividend  = a;
      divisor   = b;
      signed_op = s;
      start     = 1'b1;
      @(posedge clk);
      lat     = -1;
      busy_ok = 1'b1;
      hold_ok = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (k == 0) start = 1'b0;
         if (!busy) busy_ok = 1'b0;
         if (done) begin
            lat = k;
            break;
         end
         if (quotient !== exp_q || remainder !== exp_r || div_zero !== exp_z) hold_ok = 1'b0;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      int lat; bit bok; bit hok;
      rst_n = 1'b0; start = 1'b1; dividend = 32'd5; divisor = 32'd1; signed_op = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (quotient !== 32'd0) begin bad++; $display("FAIL reset_q got=%h exp=0", quotient); end
      total++; if (remainder !== 32'd0) begin bad++; $display("FAIL reset_r got=%h exp=0", remainder); end
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
      // Release reset with start already high: the very next edge must accept.
      rst_n = 1'b1;
      do_op(32'd1000, 32'd3, 1'b0, lat, bok, hok);
      total++; if (lat !== 33) begin bad++; $display("FAIL first_accept_latency got=%0d exp=33", lat); end
      total++; if (quotient !== 32'd333) begin bad++; $display("FAIL first_q got=%h exp=%h", quotient, 32'd333); end
      total++; if (remainder !== 32'd1) begin bad++; $display("FAIL first_r got=%h exp=1", remainder); end
      exp_q = 32'd333; exp_r = 32'd1; exp_z = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_unsigned;
      int lat; bit bok; bit hok;
      do_op(32'd100, 32'd7, 1'b0, lat, bok, hok);
      total++; if (lat !== 33) begin bad++; $display("FAIL u100_latency got=%0d exp=33", lat); end
      total++; if (!bok) begin bad++; $display("FAIL u100_busy got=low exp=high through run"); end
      total++; if (!hok) begin bad++; $display("FAIL u100_hold got=changed exp=held until done"); end
      total++; if (quotient !== 32'd14) begin bad++; $display("FAIL u100_q got=%h exp=%h", quotient, 32'd14); end
      total++; if (remainder !== 32'd2) begin bad++; $display("FAIL u100_r got=%h exp=2", remainder); end
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL u100_dz got=%b exp=0", div_zero); end
      exp_q = 32'd14; exp_r = 32'd2; exp_z = 1'b0;
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL u100_done_width got=%b exp=0", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL u100_busy_after got=%b exp=0", busy); end
      total++; if (quotient !== 32'd14) begin bad++; $display("FAIL u100_q_held got=%h exp=%h", quotient, 32'd14); end

      do_op(32'hFFFF_FFFF, 32'h10, 1'b0, lat, bok, hok);
      total++; if (quotient !== 32'h0FFF_FFFF) begin bad++; $display("FAIL umax_q got=%h exp=0fffffff", quotient); end
      total++; if (remainder !== 32'hF) begin bad++; $display("FAIL umax_r got=%h exp=f", remainder); end
      exp_q = 32'h0FFF_FFFF; exp_r = 32'hF; exp_z = 1'b0;
      @(negedge clk);

      do_op(32'h8000_0000, 32'd1, 1'b0, lat, bok, hok);
      total++; if (quotient !== 32'h8000_0000) begin bad++; $display("FAIL umin_q got=%h exp=80000000", quotient); end
      total++; if (remainder !== 32'd0) begin bad++; $display("FAIL umin_r got=%h exp=0", remainder); end
      exp_q = 32'h8000_0000; exp_r = 32'd0; exp_z = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_div_zero;
      int lat; bit bok; bit hok;
      do_op(32'h1234_5678, 32'd0, 1'b0, lat, bok, hok);
      total++; if (lat !== 33) begin bad++; $display("FAIL dz_latency got=%0d exp=33", lat); end
      total++; if (quotient !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_q got=%h exp=ffffffff", quotient); end
      total++; if (remainder !== 32'h1234_5678) begin bad++; $display("FAIL dz_r got=%h exp=12345678", remainder); end
      total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b exp=1", div_zero); end
      exp_q = 32'hFFFF_FFFF; exp_r = 32'h1234_5678; exp_z = 1'b1;
      @(negedge clk);
      total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag_held got=%b exp=1", div_zero); end

      do_op(32'd5, 32'd5, 1'b0, lat, bok, hok);
      total++; if (!hok) begin bad++; $display("FAIL dz_hold got=changed exp=held until done"); end
      total++; if (quotient !== 32'd1) begin bad++; $display("FAIL dz_next_q got=%h exp=1", quotient); end
      total++; if (remainder !== 32'd0) begin bad++; $display("FAIL dz_next_r got=%h exp=0", remainder); end
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL dz_next_flag got=%b exp=0", div_zero); end
      exp_q = 32'd1; exp_r = 32'd0; exp_z = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_signed;
      int lat; bit bok; bit hok;
      logic [31:0] eq1; logic [31:0] er1; logic [31:0] eq2; logic [31:0] er2;
`ifdef SEQ_DIVIDER_SIGNED_EN
      eq1 = 32'hFFFF_FFFD; er1 = 32'hFFFF_FFFF;   // -7 / 2 = -3 r -1
      eq2 = 32'hFFFF_FFFD; er2 = 32'd1;           //  7 / -2 = -3 r 1
`else
      eq1 = 32'h7FFF_FFFC; er1 = 32'd1;           // 0xFFFFFFF9 / 2 unsigned
      eq2 = 32'd0;         er2 = 32'd7;           // 7 / 0xFFFFFFFE unsigned
`endif
      do_op(32'hFFFF_FFF9, 32'd2, 1'b1, lat, bok, hok);
      total++; if (lat !== 33) begin bad++; $display("FAIL s_neg7_latency got=%0d exp=33", lat); end
      total++; if (quotient !== eq1) begin bad++; $display("FAIL s_neg7_q got=%h exp=%h", quotient, eq1); end
      total++; if (remainder !== er1) begin bad++; $display("FAIL s_neg7_r got=%h exp=%h", remainder, er1); end
      exp_q = eq1; exp_r = er1; exp_z = 1'b0;
      @(negedge clk);

      do_op(32'd7, 32'hFFFF_FFFE, 1'b1, lat, bok, hok);
      total++; if (quotient !== eq2) begin bad++; $display("FAIL s_negdiv_q got=%h exp=%h", quotient, eq2); end
      total++; if (remainder !== er2) begin bad++; $display("FAIL s_negdiv_r got=%h exp=%h", remainder, er2); end
      exp_q = eq2; exp_r = er2; exp_z = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_overflow;
      int lat; bit bok; bit hok;
      logic [31:0] eq; logic [31:0] er;
`ifdef SEQ_DIVIDER_SIGNED_EN
      eq = 32'h8000_0000; er = 32'd0;
`else
      eq = 32'd0; er = 32'h8000_0000;
`endif
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bok, hok);
      total++; if (quotient !== eq) begin bad++; $display("FAIL ovf_q got=%h exp=%h", quotient, eq); end
      total++; if (remainder !== er) begin bad++; $display("FAIL ovf_r got=%h exp=%h", remainder, er); end
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL ovf_dz got=%b exp=0", div_zero); end
      exp_q = eq; exp_r = er; exp_z = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int done_cnt; int busy_cnt;
      dividend = 32'd1000; divisor = 32'd10; signed_op = 1'b0; start = 1'b1;
      @(posedge clk);                 // E0
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(posedge clk);      // E1..E9
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);                 // E10 with reset asserted
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b exp=0", done); end
      total++; if (quotient !== 32'd0) begin bad++; $display("FAIL rmid_q got=%h exp=0", quotient); end
      total++; if (remainder !== 32'd0) begin bad++; $display("FAIL rmid_r got=%h exp=0", remainder); end
      exp_q = 32'd0; exp_r = 32'd0; exp_z = 1'b0;
      rst_n = 1'b1;
      done_cnt = 0; busy_cnt = 0;
      for (int k = 0; k < 45; k++) begin
         @(negedge clk);
         if (done) done_cnt++;
         if (busy) busy_cnt++;
      end
      total++; if (done_cnt !== 0) begin bad++; $display("FAIL rmid_no_done got=%0d exp=0", done_cnt); end
      total++; if (busy_cnt !== 0) begin bad++; $display("FAIL rmid_no_busy got=%0d exp=0", busy_cnt); end
   endtask

   task automatic test_busy_ignore;
      int lat; int busy_cnt;
      dividend = 32'd100; divisor = 32'd9; signed_op = 1'b0; start = 1'b1;
      @(posedge clk);                 // E0
      lat = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (k == 0) start = 1'b0;
         if (k == 4) begin             // high across E5 only
            start = 1'b1; dividend = 32'd50; divisor = 32'd5;
         end
         if (k == 5) start = 1'b0;
         if (done) begin
            lat = k;
            break;
         end
      end
      total++; if (lat !== 33) begin bad++; $display("FAIL ign_latency got=%0d exp=33", lat); end
      total++; if (quotient !== 32'd11) begin bad++; $display("FAIL ign_q got=%h exp=%h", quotient, 32'd11); end
      total++; if (remainder !== 32'd1) begin bad++; $display("FAIL ign_r got=%h exp=1", remainder); end
      exp_q = 32'd11; exp_r = 32'd1; exp_z = 1'b0;
      busy_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
      end
      total++; if (busy_cnt !== 0) begin bad++; $display("FAIL ign_no_queue got=%0d exp=0", busy_cnt); end
   endtask

   task automatic test_back_to_back;
      int lat; bit hok;
      dividend = 32'd20; divisor = 32'd3; signed_op = 1'b0; start = 1'b1;
      @(posedge clk);                 // first E0
      lat = -1; hok = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (k == 0) begin dividend = 32'd45; divisor = 32'd4; end   // start stays high
         if (done) begin
            lat = k;
            break;
         end
         if (quotient !== exp_q || remainder !== exp_r || div_zero !== exp_z) hok = 1'b0;
      end
      total++; if (lat !== 33) begin bad++; $display("FAIL b2b_1_latency got=%0d exp=33", lat); end
      total++; if (!hok) begin bad++; $display("FAIL b2b_1_hold got=changed exp=held until done"); end
      total++; if (quotient !== 32'd6) begin bad++; $display("FAIL b2b_1_q got=%h exp=6", quotient); end
      total++; if (remainder !== 32'd2) begin bad++; $display("FAIL b2b_1_r got=%h exp=2", remainder); end
      exp_q = 32'd6; exp_r = 32'd2; exp_z = 1'b0;
      @(negedge clk);                 // after DONE->IDLE
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap got=%b exp=0", busy); end
      @(negedge clk);                 // after second accept
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_2_accept got=%b exp=1", busy); end
      start = 1'b0;
      lat = -1; hok = 1'b1;
      for (int k = 1; k < 60; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
         if (quotient !== exp_q || remainder !== exp_r || div_zero !== exp_z) hok = 1'b0;
      end
      total++; if (lat !== 33) begin bad++; $display("FAIL b2b_2_latency got=%0d exp=33", lat); end
      total++; if (!hok) begin bad++; $display("FAIL b2b_2_hold got=changed exp=held until done"); end
      total++; if (quotient !== 32'd11) begin bad++; $display("FAIL b2b_2_q got=%h exp=%h", quotient, 32'd11); end
      total++; if (remainder !== 32'd1) begin bad++; $display("FAIL b2b_2_r got=%h exp=1", remainder); end
      exp_q = 32'd11; exp_r = 32'd1; exp_z = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst_n = 1'b0; start = 1'b0; signed_op = 1'b0;
      dividend = 32'd0; divisor = 32'd0;
      test_reset;
      test_unsigned;
      test_div_zero;
      test_signed;
      test_overflow;
      test_reset_mid;
      test_busy_ignore;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports: clk input 1, rising-edge clock; rst_n input 1, synchronous active-low reset.
REQ-002 The block SHALL have these ports:
- start input 1: request a divide; sampled only in IDLE.
- signed_op input 1: 1 = signed (DIV), 0 = unsigned (DIVU).
- dividend input 32: numerator, captured when start is accepted.
- divisor input 32: denominator, captured when start is accepted.
- quotient output 32: registered result.
- remainder output 32: registered result.
- busy output 1: high from the start-accept edge until done falls.
- done output 1: one-cycle completion pulse.
- div_zero output 1: divisor was 0; valid with done, held with the results.
REQ-003 The block SHALL have no parameters; the width is fixed at 32.

Function
REQ-004 The block SHALL implement an FSM with four states.
- IDLE -> RUN: on start=1.
- RUN -> FIX: after 32 iterations.
- FIX -> DONE: unconditional.
- DONE -> IDLE: unconditional.
REQ-005 Start accept (edge E0): the block SHALL latch the operands, the sign flags and signed_op; clear the partial remainder; and load the iteration counter with 31.
REQ-006 Each RUN edge (E1..E32) SHALL perform one restoring step, MSB first:
- shift {remainder, dividend magnitude} left by 1;
- trial-subtract the divisor magnitude, 33-bit wide;
- if the result is non-negative, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
REQ-007 At edge E33 (FIX->DONE) the block SHALL register the corrected quotient, remainder and div_zero, and assert done.
REQ-008 done SHALL be high exactly during the cycle following E33, for one cycle.
REQ-009 Latency SHALL be fixed at 33 edges from accept to the rising edge of done, independent of operand values.
REQ-010 busy SHALL be high in RUN, FIX and DONE, and low in IDLE.
REQ-011 start while busy=1 SHALL be ignored, with no queuing.
REQ-012 start held high SHALL begin a new operation at the first edge back in IDLE.
REQ-013 quotient, remainder and div_zero SHALL hold their values from done until the FIX->DONE edge of the next operation; they SHALL NOT change during RUN.
REQ-014 Divisor=0 SHALL keep the full latency and produce:
- quotient = 0xFFFFFFFF;
- remainder = dividend, as captured;
- div_zero = 1.
REQ-015 In unsigned mode the block SHALL produce quotient = floor(dividend/divisor) and remainder = dividend mod divisor.
REQ-016 Arithmetic SHALL be carried out on magnitudes; 0x80000000 SHALL be treated as magnitude 2^31 without overflow.

Reset
REQ-017 rst_n=0 at a rising edge SHALL force the following, regardless of state, including mid-RUN:
- state = IDLE;
- quotient = 0 and remainder = 0;
- busy = 0, done = 0, div_zero = 0;
- counter and internal registers = 0.
REQ-018 An operation interrupted by reset SHALL be discarded, with no done pulse.
REQ-019 The first start SHALL be accepted at the first edge with rst_n=1.

Configuration
REQ-020 The macro SEQ_DIVIDER_SIGNED_EN SHALL control signed support.
- Defined: signed_op=1 uses the magnitudes of the two's-complement operands. The quotient is negated when the operand signs differ, and truncates toward zero. The remainder takes the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, div_zero 0. Sign correction happens in FIX.
- Undefined: signed_op is ignored and treated as 0. All operations are unsigned. FIX passes values through.
REQ-021 Latency and port list SHALL be identical with and without the macro.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Unsigned: dividend=100, divisor=7, signed_op=0 -> at E33: quotient=14, remainder=2, done pulse 1 cycle, busy high E0..E33+1.
- Divide by zero: dividend=0x12345678, divisor=0 -> quotient=0xFFFFFFFF, remainder=0x12345678, div_zero=1, latency 33.
- Signed, macro defined: dividend=-7 (0xFFFFFFF9), divisor=2, signed_op=1 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). With the macro undefined -> quotient=0x7FFFFFFC, remainder=1.
- Overflow, macro defined: 0x80000000 / 0xFFFFFFFF signed -> quotient=0x80000000, remainder=0, div_zero=0.
- Reset and busy: rst_n=0 at E10 of an operation -> next cycle busy=0, outputs 0, no done. A start pulse at E5 of another operation is ignored, and its results match the first operands only.
- Back-to-back: start held high across two operations -> the second accept occurs 1 edge after the done cycle ends (in IDLE). Outputs are unchanged until the second E33.
